i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with register-bus control and open-drain sda
//
// Purpose: I2C slave (7-bit addressing, no clock stretching) controlled through
//          a zero-wait-state register bus. Received bytes land in RXDATA, and
//          transmitted bytes come from TXDATA.
// Ports:
//   clk, rstn         system clock, asynchronous active-low reset
//   sel, enable       bus select / access phase; ready = sel & enable
//   write, addr       access direction and byte address
//   wdata, rdata      write data in, read data out (valid in the access cycle)
//   sda               open-drain data line (drives 0 or Z only)
//   scl               bus clock from the master
// Register map: 0x00 CTRL{EN}, 0x04 OWN_ADDR[6:0],
//               0x08 STATUS{MNACK,DIR,OVERRUN,RX_VALID,BUSY}, 0x0C TXDATA,
//               0x10 RXDATA
module i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sel,
  input  logic       enable,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  inout  wire        sda,
  input  logic       scl
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_RX       = 3'd3;
  localparam logic [2:0] S_RX_ACK   = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;
  localparam logic [2:0] S_TX_ACK   = 3'd6;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_sda_oe;
  logic       r_ctrl_en;
  logic [6:0] r_own_addr;
  logic [7:0] r_txdata;
  logic [7:0] r_rxdata;
  logic       r_busy;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_dir;
  logic       r_mnack;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_access;
  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_status;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // scl must be high on both samples, so START and STOP can never coincide
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign w_access = sel & enable & rstn;
  assign w_wr     = w_access & write;
  assign w_rd     = w_access & ~write;
  assign ready    = w_access;
  assign w_status = {3'b000, r_mnack, r_dir, r_overrun, r_rx_valid, r_busy};

  // Gating with EN releases the line the moment EN is cleared; reset clears
  // r_sda_oe asynchronously, which releases it within the same cycle
  assign sda = (r_sda_oe && r_ctrl_en) ? 1'b0 : 1'bz;

  always_comb begin
    rdata = 8'h00;
    if (w_rd) begin
      case (addr)
        8'h00:   rdata = {7'b0, r_ctrl_en};
        8'h04:   rdata = {1'b0, r_own_addr};
        8'h08:   rdata = w_status;
        8'h0C:   rdata = r_txdata;
        8'h10:   rdata = r_rxdata;
        default: rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // Idle-bus preset: no false START/STOP when reset is released
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_ctrl_en  <= 1'b0;
      r_own_addr <= 7'h00;
      r_txdata   <= 8'h00;
      r_rxdata   <= 8'h00;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_dir      <= 1'b0;
      r_mnack    <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;

      // Bus side first; protocol events below override it (set beats clear)
      if (w_wr) begin
        case (addr)
          8'h00: r_ctrl_en  <= wdata[0];
          8'h04: r_own_addr <= wdata[6:0];
          8'h08: begin
            if (wdata[2]) r_overrun <= 1'b0;
            if (wdata[4]) r_mnack   <= 1'b0;
          end
          8'h0C: r_txdata <= wdata;
          default: ;
        endcase
      end
      if (w_rd && addr == 8'h10) r_rx_valid <= 1'b0;

      if (!r_ctrl_en) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= 4'd0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= 4'd0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_sda_oe <= 1'b0;
        r_cnt    <= 4'd0;
      end else begin
        case (r_state)
          S_ADDR, S_RX: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == r_own_addr) begin
                  r_state  <= S_ADDR_ACK;
                  r_sda_oe <= 1'b1;
                  r_busy   <= 1'b1;
                  r_dir    <= r_shift[0];
                end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_state <= S_RX_ACK;
                if (!r_rx_valid) begin
                  r_rxdata   <= r_shift;
                  r_rx_valid <= 1'b1;
                  r_sda_oe   <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                  r_sda_oe  <= 1'b0;
                end
              end
            end
          end
          // r_cnt == 1 marks that the 9th-clock rising edge has been seen
          S_ADDR_ACK, S_RX_ACK: begin
            if (w_scl_rise) begin
              r_cnt <= 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd1) begin
              r_cnt <= 4'd0;
              if (r_state == S_ADDR_ACK && r_dir) begin
                r_state  <= S_TX;
                r_shift  <= r_txdata;
                r_sda_oe <= ~r_txdata[7];
              end else begin
                r_state  <= S_RX;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_TX: begin
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_state  <= S_TX_ACK;
                r_sda_oe <= 1'b0;
                r_cnt    <= 4'd0;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_mnack <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_cnt <= 4'd1;
              end
            end else if (w_scl_fall && r_cnt == 4'd1) begin
              r_state  <= S_TX;
              r_shift  <= r_txdata;
              r_sda_oe <= ~r_txdata[7];
              r_cnt    <= 4'd0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
